// File: rtl/wb_pkg.sv
// Shared types and default widths for the scalar writeback arbiter.
//
// Optional feature macro: WB_WAW_SQUASH_EN
//   When defined, each buffered load-return entry carries a squash bit so that
//   a queued load can be cancelled by a younger execute write to the same
//   register.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 36;
  localparam int unsigned WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
`ifdef WB_WAW_SQUASH_EN
    logic                 squash;
`endif
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of wb_entry_t holding load returns waiting for the
// register-file write port.
//
// Optional feature macro: WB_WAW_SQUASH_EN (adds squash_en/squash_addr).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push         store push_entry at the tail (ignored when full)
//   push_entry   entry to store
//   pop          drop the head (ignored when empty)
//   head         current head entry
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
//   squash_en    [macro] mark every stored entry whose addr == squash_addr
//   squash_addr  [macro] register address being overwritten by execute
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  output wb_entry_t            head,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
`ifdef WB_WAW_SQUASH_EN
  ,
  input  logic                 squash_en,
  input  logic [WB_ADDR_W-1:0] squash_addr
`endif
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which slots are live.
  always_ff @(posedge clk) begin
`ifdef WB_WAW_SQUASH_EN
    // Free slots may be marked too; harmless, they are rewritten on push.
    if (squash_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem[PTR_W'(i)].addr == squash_addr) mem[PTR_W'(i)].squash <= 1'b1;
      end
    end
`endif
    // The push slot is never live, so this write cannot lose a squash mark;
    // a same-cycle match is already folded into push_entry.squash.
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Writeback stage driving the single write port of the scalar register file.
// Execute results always win the port with one cycle of latency; load returns
// are buffered in wb_fifo and written in arrival order in cycles where execute
// does not write.
//
// Optional feature macro: WB_WAW_SQUASH_EN
//   Queued loads whose destination is overwritten by an execute result are
//   squashed and later popped without writing.
//
// DATA_W/ADDR_W must match wb_pkg::WB_DATA_W/WB_ADDR_W (the entry type is
// fixed by the package).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_valid/addr/data execute result (no back-pressure)
//   mem_valid/addr/data, mem_ready  load return handshake
//   we, write_addr, write_data      registered register-file write port
//   pending_cnt       FIFO occupancy (includes squashed entries)
module scalar_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic [ADDR_W-1:0]      ex_addr,
  input  logic [DATA_W-1:0]      ex_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   we,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [DATA_W-1:0]      write_data,
  output logic [$clog2(DEPTH):0] pending_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic             head_squash;
  logic             load_wr;

  // Derived only from the registered count: no mem_valid -> mem_ready path.
  assign mem_ready   = !fifo_full;
  assign pending_cnt = fifo_count;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = mem_addr;
    push_entry.data = mem_data;
`ifdef WB_WAW_SQUASH_EN
    // Same-cycle match: the load is older than the execute write.
    push_entry.squash = ex_valid && (mem_addr == ex_addr);
    head_squash       = head.squash;
`else
    head_squash       = 1'b0;
`endif
    push    = mem_valid && mem_ready;
    // A squashed head leaves even while execute owns the port.
    pop     = !fifo_empty && (!ex_valid || head_squash);
    load_wr = pop && !head_squash;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
`ifdef WB_WAW_SQUASH_EN
    ,
    .squash_en   (ex_valid),
    .squash_addr (ex_addr)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we         <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      we <= ex_valid || load_wr;
      if (ex_valid) begin
        write_addr <= ex_addr;
        write_data <= ex_data;
      end else if (load_wr) begin
        write_addr <= head.addr;
        write_data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
module tb_scalar_writeback_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 36;
  localparam int DEPTH  = 4;
`ifdef WB_WAW_SQUASH_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ex_valid = 1'b0;
  logic [ADDR_W-1:0] ex_addr = '0;
  logic [DATA_W-1:0] ex_data = '0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [2:0]        pending_cnt;

  scalar_writeback_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_addr     (ex_addr),
    .ex_data     (ex_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .we          (we),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                sq;
  } ent_t;

  ent_t              q[$];
  logic              exp_we   = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      bit   room;
      bit   hsq;
      bit   pop_it;
      ent_t e;
      room   = q.size() < DEPTH;
      hsq    = (q.size() > 0) && q[0].sq;
      pop_it = (q.size() > 0) && (!ex_valid || hsq);
      if (ex_valid) begin
        exp_we = 1'b1; exp_addr = ex_addr; exp_data = ex_data;
      end else if (pop_it && !hsq) begin
        exp_we = 1'b1; exp_addr = q[0].addr; exp_data = q[0].data;
      end else begin
        exp_we = 1'b0;
      end
      if (pop_it) void'(q.pop_front());
      if (SQ_EN && ex_valid)
        foreach (q[i]) if (q[i].addr == ex_addr) q[i].sq = 1'b1;
      if (mem_valid && room) begin
        e.addr = mem_addr;
        e.data = mem_data;
        e.sq   = SQ_EN && ex_valid && (mem_addr == ex_addr);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_we", we, exp_we);
    chk("cmp_write_addr", write_addr, exp_addr);
    chk("cmp_write_data", write_data, exp_data);
    chk("cmp_pending_cnt", pending_cnt, q.size());
    chk("cmp_mem_ready", mem_ready, q.size() != DEPTH);
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t wlog[$];

  task automatic tick();
    wr_t w;
    @(negedge clk);
    #1;
    if (we === 1'b1) begin
      w.a = write_addr;
      w.d = write_data;
      wlog.push_back(w);
    end
  endtask

  task automatic set_in(input logic ev, input int ea, input logic [DATA_W-1:0] ed,
                        input logic mv, input int ma, input logic [DATA_W-1:0] md);
    ex_valid  = ev;
    ex_addr   = ADDR_W'(ea);
    ex_data   = ed;
    mem_valid = mv;
    mem_addr  = ADDR_W'(ma);
    mem_data  = md;
  endtask

  function automatic int count_wr(input int a, input logic [DATA_W-1:0] d);
    int n = 0;
    foreach (wlog[i]) if (wlog[i].a == ADDR_W'(a) && wlog[i].d == d) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  acc;
    bit  took;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_we", we, 1'b0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_ready", mem_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Execute write: one-cycle latency.
    set_in(1, 7, 36'h012345678, 0, 0, '0);
    tick();
    set_in(0, 0, '0, 0, 0, '0);
    chk("ex_we", we, 1'b1);
    chk("ex_addr", write_addr, 7);
    chk("ex_data", write_data, 36'h012345678);

    // Single load into idle arbiter: written two cycles later.
    set_in(0, 0, '0, 1, 3, 36'hABC);
    tick();
    set_in(0, 0, '0, 0, 0, '0);
    chk("ld_pending_n1", pending_cnt, 1);
    chk("ld_we_n1", we, 1'b0);
    tick();
    chk("ld_we", we, 1'b1);
    chk("ld_addr", write_addr, 3);
    chk("ld_data", write_data, 36'hABC);
    chk("ld_pending_n2", pending_cnt, 0);

    // Fill under execute pressure, then drain in order with wrap.
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (acc < 5) set_in(1, 20 + c, DATA_W'(32'h200 + c), 1, 11 + acc, DATA_W'(32'h101 + acc));
      else         set_in(1, 20 + c, DATA_W'(32'h200 + c), 0, 0, '0);
      took = mem_valid && mem_ready;
      tick();
      if (took) acc++;
      if (c == 3) begin
        chk("fill_ready", mem_ready, 1'b0);
        chk("fill_pending", pending_cnt, 4);
        chk("fill_accepted", acc, 4);
      end
    end
    chk("fill_held_5th", acc, 4);
    wlog.delete();
    for (int c = 0; c < 10; c++) begin
      if (acc < 5) set_in(0, 0, '0, 1, 11 + acc, DATA_W'(32'h101 + acc));
      else         set_in(0, 0, '0, 0, 0, '0);
      took = mem_valid && mem_ready;
      tick();
      if (took) acc++;
      if (c == 0) chk("drain_pending", pending_cnt, 3);
    end
    chk("drain_accepted", acc, 5);
    chk("drain_nwrites", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) begin
        chk("drain_order_addr", wlog[i].a, 11 + i);
        chk("drain_order_data", wlog[i].d, 32'h101 + i);
      end
    end

    // Concurrent push and pop with two entries stored.
    set_in(1, 1, 36'h301, 1, 16, 36'h401);
    tick();
    set_in(1, 2, 36'h302, 1, 17, 36'h402);
    tick();
    chk("cc_pending_pre", pending_cnt, 2);
    set_in(0, 0, '0, 1, 18, 36'h403);
    tick();
    set_in(0, 0, '0, 0, 0, '0);
    chk("cc_pending", pending_cnt, 2);
    chk("cc_we", we, 1'b1);
    chk("cc_addr", write_addr, 16);
    chk("cc_data", write_data, 36'h401);
    repeat (3) tick();
    chk("cc_empty", pending_cnt, 0);

    // WAW: loads to r5, r6 queued, then execute writes r5.
    wlog.delete();
    set_in(1, 1, 36'h501, 1, 5, 36'h55);
    tick();
    set_in(1, 2, 36'h502, 1, 6, 36'h66);
    tick();
    set_in(1, 5, 36'hE5, 0, 0, '0);
    tick();
    set_in(0, 0, '0, 0, 0, '0);
    repeat (4) tick();
    chk("waw_r5_load", count_wr(5, 36'h55), SQ_EN ? 0 : 1);
    chk("waw_r5_ex", count_wr(5, 36'hE5), 1);
    chk("waw_r6_load", count_wr(6, 36'h66), 1);

    // Same-cycle push and execute to r9.
    wlog.delete();
    set_in(1, 9, 36'hE9, 1, 9, 36'h99);
    tick();
    set_in(0, 0, '0, 0, 0, '0);
    repeat (3) tick();
    chk("same_ex", count_wr(9, 36'hE9), 1);
    chk("same_ld", count_wr(9, 36'h99), SQ_EN ? 0 : 1);

    // Mid-operation reset with three entries held and execute active.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 3, 36'h600, 1, 20 + i, DATA_W'(32'h700 + i));
      tick();
    end
    chk("mrst_pending_pre", pending_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_we", we, 1'b0);
    chk("mrst_pending", pending_cnt, 0);
    chk("mrst_ready", mem_ready, 1'b1);
    wlog.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    set_in(0, 0, '0, 0, 0, '0);
    repeat (5) tick();
    chk("mrst_no_stale", wlog.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
